// File: rtl/prime_key_gen_if.sv
// Random-word source and Miller-Rabin tester signals of prime_key_gen.
// The generator connects through master and the environment through slave.
interface prime_key_gen_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             mr_start;
  logic [WIDTH-1:0] mr_candidate;
  logic [WIDTH-1:0] mr_accuracy;
  logic             mr_done;
  logic             mr_prime;

  modport master (
    input  rnd_data, rnd_valid, mr_done, mr_prime,
    output rnd_ready, mr_start, mr_candidate, mr_accuracy
  );

  modport slave (
    output rnd_data, rnd_valid, mr_done, mr_prime,
    input  rnd_ready, mr_start, mr_candidate, mr_accuracy
  );
endinterface

// File: rtl/prime_key_gen.sv
// Prime key generator: shapes random words into odd full-width candidates,
// has them tested externally and collects NUM_KEYS distinct primes per run.
module prime_key_gen #(
  parameter int WIDTH     = 32,
  parameter int NUM_KEYS  = 2,
  parameter int MAX_TRIES = 1024,
  parameter int ACCURACY  = 8,
  localparam int KCW = $clog2(NUM_KEYS + 1),
  localparam int TW  = $clog2(MAX_TRIES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [KCW-1:0]            key_count,
  output logic [NUM_KEYS*WIDTH-1:0] keys_out,
  output logic [TW-1:0]             tries,
  prime_key_gen_if.master           bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] candidate;
  logic             prime_q;
  logic             dup;
  logic             accept;
  logic [KCW-1:0]   count_inc;
  logic             rnd_ready_c;
  logic             mr_start_c;
  logic             rnd_unused;

  // The top and bottom random bits are replaced by forced ones.
  assign rnd_unused = bus.rnd_data[WIDTH-1] ^ bus.rnd_data[0];

  assign bus.rnd_ready    = rnd_ready_c;
  assign bus.mr_start     = mr_start_c;
  assign bus.mr_candidate = candidate;
  assign bus.mr_accuracy  = WIDTH'(ACCURACY);

  // A candidate equal to any already accepted key is a duplicate.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KCW'(i) < key_count && keys_out[i*WIDTH +: WIDTH] == candidate)
        dup = 1'b1;
    end
  end

  assign accept    = prime_q && !dup;
  assign count_inc = key_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    fail        = 1'b0;
    rnd_ready_c = 1'b0;
    mr_start_c  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        rnd_ready_c = 1'b1;
        if (bus.rnd_valid) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        mr_start_c = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:   if (bus.mr_done) state_next = S_CHECK;
      // Completing the key set wins over running out of tries.
      S_CHECK: begin
        if (accept && count_inc == KCW'(NUM_KEYS)) state_next = S_DONE;
        else if (tries == TW'(MAX_TRIES))          state_next = S_FAIL;
        else                                       state_next = S_FETCH;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_FAIL: begin
        fail       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_out  <= '0;
      key_count <= '0;
      tries     <= '0;
      candidate <= '0;
      prime_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            keys_out  <= '0;
            key_count <= '0;
            tries     <= '0;
          end
        end
        S_FETCH: begin
          if (bus.rnd_valid)
            candidate <= {1'b1, bus.rnd_data[WIDTH-2:1], 1'b1};
        end
        S_LAUNCH: tries <= tries + 1'b1;
        S_WAIT: begin
          if (bus.mr_done) prime_q <= bus.mr_prime;
        end
        S_CHECK: begin
          if (accept) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
              if (KCW'(i) == key_count) keys_out[i*WIDTH +: WIDTH] <= candidate;
            end
            key_count <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
